instr_fetch_queue: RTL and testbench

Instruction prefetch queue sitting directly upstream of the pipelined processor's IF/ID register. It replaces the zero-latency instruction memory lookup with a single-outstanding request/acknowledge fetch port to a multi-cycle instruction memory. It buffers up to DEPTH sequential instructions with their PCs, and flushes and refetches on any control-flow redirect (jump, jr, taken branch) signalled by the hazard logic. All state updates on the falling edge of CLK, matching the pipeline registers.

---
 rtl/instr_fetch_queue.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Prefetch queue in front of the IF/ID register. Issues one outstanding
//   request at a time to a multi-cycle instruction memory. Buffers up to
//   DEPTH {instr, pc} entries. Flushes and refetches on a control-flow
//   redirect. All state changes on the falling edge of CLK.
//
// Ports
//   CLK            pipeline clock (state updates on negedge)
//   Reset_L        synchronous active-low reset
//   startPC        first fetch address, loaded during reset
//   mem_req        registered fetch request
//   mem_addr       fetch address, held while mem_req=1
//   mem_ack        memory accepts the request and returns data this edge
//   mem_rdata      instruction word, valid with mem_ack
//   pop            consume the head entry
//   redirect       flush the queue and restart fetching at redirect_pc
//   redirect_pc    new fetch address
//   instr_valid    head entry present
//   instr          head instruction word (0 when empty)
//   instr_pc       head PC (0 when empty)
//   instr_pcplus4  head PC + 4 (0 when empty)
//   count          current occupancy
module instr_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     Reset_L,
  input  logic [31:0]              startPC,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  input  logic                     pop,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  output logic [31:0]              instr_pcplus4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  typedef enum logic {
    FETCH,
    DRAIN
  } fetchState_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t      entries [DEPTH];
  fetchState_t state, stateNext;
  logic [31:0] fetchPc, fetchPcNext;
  logic [PtrW-1:0] rdPtr, rdPtrNext, wrPtr, wrPtrNext;
  logic [PtrW:0]   countNext;
  logic        memReqNext;
  logic [31:0] memAddrNext;
  logic        handshake, push, doPop;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    handshake   = mem_req & mem_ack;
    // Data returned while draining, or on a redirect edge, belongs to the
    // abandoned stream and is dropped.
    push        = handshake & (state == FETCH) & ~redirect;
    doPop       = pop & (count != '0) & ~redirect;

    stateNext   = state;
    case (state)
      FETCH: if (redirect & mem_req & ~mem_ack) stateNext = DRAIN;
      DRAIN: if (handshake)                     stateNext = FETCH;
      default:                                  stateNext = FETCH;
    endcase

    fetchPcNext = fetchPc;
    if (redirect)  fetchPcNext = redirect_pc;
    else if (push) fetchPcNext = fetchPc + 32'd4;

    rdPtrNext   = rdPtr + PtrW'(doPop);
    wrPtrNext   = wrPtr + PtrW'(push);
    countNext   = count + (PtrW + 1)'(push) - (PtrW + 1)'(doPop);
    if (redirect) begin
      rdPtrNext = '0;
      wrPtrNext = '0;
      countNext = '0;
    end

    // While draining the old request must stay asserted at its original
    // address; otherwise request whenever the queue will have room.
    memReqNext  = (stateNext == DRAIN) | (countNext != FullCount);
    memAddrNext = (stateNext == DRAIN) ? mem_addr : fetchPcNext;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(negedge CLK) begin
    if (!Reset_L) begin
      state    <= FETCH;
      fetchPc  <= startPC;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= stateNext;
      fetchPc  <= fetchPcNext;
      rdPtr    <= rdPtrNext;
      wrPtr    <= wrPtrNext;
      count    <= countNext;
      mem_req  <= memReqNext;
      mem_addr <= memAddrNext;
    end
  end

  // NOTE: the entry storage has no reset; count gates every read, so stale
  // contents are never observable.
  always_ff @(negedge CLK) begin
    if (Reset_L && push) entries[wrPtr] <= '{instr: mem_rdata, pc: mem_addr};
  end

  always_comb begin
    instr_valid   = (count != '0);
    instr         = '0;
    instr_pc      = '0;
    instr_pcplus4 = '0;
    if (instr_valid) begin
      instr         = entries[rdPtr].instr;
      instr_pc      = entries[rdPtr].pc;
      instr_pcplus4 = entries[rdPtr].pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue. Inputs change 1 time unit after
// the rising edge; the DUT updates on the falling edge. A memory model
// answers requests after memLat cycles (0 = ack tied high). The scoreboard
// holds the PCs expected to be consumed; the monitor compares the head entry
// on every cycle where a pop will take effect.
module tb_instr_fetch_queue;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic [31:0] startPC;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata;
  logic        pop;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;
  int memLat = 0;
  logic [31:0] expQ [$];

  instr_fetch_queue #(.DEPTH(4)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .startPC(startPC),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .pop(pop), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_pcplus4(instr_pcplus4), .count(count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  assign mem_rdata = memWord(mem_addr);

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset(input logic [31:0] s, input int lat);
    memLat   = lat;
    startPC  = s;
    Reset_L  = 1'b0;
    pop      = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    tick();
    Reset_L  = 1'b1;
  endtask

  // Memory: counts cycles of an outstanding request, acks after memLat.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge CLK);
      #2;
      if (memLat == 0) begin
        mem_ack = 1'b1;
        cnt = 0;
      end else if (!mem_req) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else begin
        if (mem_ack) cnt = 0;   // previous request completed; a new one is up
        cnt++;
        mem_ack = (cnt >= memLat);
      end
    end
  end

  // Monitor: compares the head entry whenever a pop will consume it.
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge CLK);
      #4;
      if (Reset_L === 1'b1 && pop && !redirect && instr_valid) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got pc %h expected none", instr_pc);
        end else begin
          e = expQ.pop_front();
          check("sb_pc", instr_pc, e);
          check("sb_instr", instr, memWord(e));
          check("sb_pcplus4", instr_pcplus4, e + 32'd4);
        end
      end
    end
  end

  task automatic checkEmptySb(input string name);
    check(name, 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin
    Reset_L = 1'b0; startPC = '0; pop = 1'b0; redirect = 1'b0;
    redirect_pc = '0;
    tick();

    // Reset state, then streaming with ack tied high and pop every cycle.
    doReset(32'h100, 0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_pcplus4", instr_pcplus4, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    for (int i = 0; i < 8; i++) expQ.push_back(32'h100 + 32'(4 * i));
    pop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("s1_count_le1", 32'(count <= 3'd1), 32'd1);
    end
    pop = 1'b0;
    tick();
    checkEmptySb("s1_sb_empty");

    // Fill to DEPTH with no pops, then release one slot.
    doReset(32'h100, 0);
    repeat (5) tick();
    check("s2_full_count", 32'(count), 32'd4);
    check("s2_full_req", 32'(mem_req), 32'd0);
    check("s2_full_addr", mem_addr, 32'h110);
    check("s2_head_pc", instr_pc, 32'h100);
    tick();
    check("s2_hold_count", 32'(count), 32'd4);
    expQ.push_back(32'h100);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("s2_pop_count", 32'(count), 32'd3);
    check("s2_pop_req", 32'(mem_req), 32'd1);
    check("s2_pop_addr", mem_addr, 32'h110);
    tick();
    check("s2_refill_count", 32'(count), 32'd4);
    check("s2_refill_req", 32'(mem_req), 32'd0);
    check("s2_refill_addr", mem_addr, 32'h114);
    for (int i = 1; i < 8; i++) expQ.push_back(32'h100 + 32'(4 * i));
    pop = 1'b1;
    repeat (7) tick();
    pop = 1'b0;
    tick();
    checkEmptySb("s2_sb_empty");

    // 3-cycle memory, redirect while the 0x10C request is outstanding.
    doReset(32'h100, 3);
    repeat (10) tick();
    check("s3_pre_count", 32'(count), 32'd3);
    check("s3_pre_addr", mem_addr, 32'h10C);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    check("s3_flush_count", 32'(count), 32'd0);
    check("s3_drain_req", 32'(mem_req), 32'd1);
    check("s3_drain_addr", mem_addr, 32'h10C);
    tick();
    check("s3_drain_addr2", mem_addr, 32'h10C);
    check("s3_valid_a", 32'(instr_valid), 32'd0);
    tick();
    check("s3_new_addr", mem_addr, 32'h200);
    check("s3_valid_b", 32'(instr_valid), 32'd0);
    tick();
    check("s3_valid_c", 32'(instr_valid), 32'd0);
    tick();
    check("s3_valid_d", 32'(instr_valid), 32'd0);
    tick();
    check("s3_first_valid", 32'(instr_valid), 32'd1);
    check("s3_first_pc", instr_pc, 32'h200);
    check("s3_first_count", 32'(count), 32'd1);
    expQ.push_back(32'h200);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    tick();
    checkEmptySb("s3_sb_empty");

    // Redirect coincident with the ack for 0x108 and a pop.
    doReset(32'h100, 0);
    repeat (3) tick();
    check("s4_pre_addr", mem_addr, 32'h108);
    check("s4_pre_count", 32'(count), 32'd2);
    redirect = 1'b1;
    redirect_pc = 32'h300;
    pop = 1'b1;
    tick();
    redirect = 1'b0;
    pop = 1'b0;
    check("s4_count", 32'(count), 32'd0);
    check("s4_valid", 32'(instr_valid), 32'd0);
    check("s4_req", 32'(mem_req), 32'd1);
    check("s4_addr", mem_addr, 32'h300);
    tick();
    check("s4_head_pc", instr_pc, 32'h300);
    check("s4_head_count", 32'(count), 32'd1);
    expQ.push_back(32'h300);
    expQ.push_back(32'h304);
    pop = 1'b1;
    repeat (2) tick();
    pop = 1'b0;
    tick();
    checkEmptySb("s4_sb_empty");

    // Reset mid-burst with three entries and a request outstanding.
    doReset(32'h100, 0);
    repeat (4) tick();
    check("s5_pre_count", 32'(count), 32'd3);
    check("s5_pre_req", 32'(mem_req), 32'd1);
    startPC = 32'h400;
    Reset_L = 1'b0;
    tick();
    check("s5_req", 32'(mem_req), 32'd0);
    check("s5_addr", mem_addr, 32'd0);
    check("s5_valid", 32'(instr_valid), 32'd0);
    check("s5_instr", instr, 32'd0);
    check("s5_pc", instr_pc, 32'd0);
    check("s5_pcplus4", instr_pcplus4, 32'd0);
    check("s5_count", 32'(count), 32'd0);
    Reset_L = 1'b1;
    tick();
    check("s5_first_req", 32'(mem_req), 32'd1);
    check("s5_first_addr", mem_addr, 32'h400);

    // Address wrap at the top of the 32-bit space.
    doReset(32'hFFFF_FFF8, 0);
    expQ.push_back(32'hFFFF_FFF8);
    expQ.push_back(32'hFFFF_FFFC);
    expQ.push_back(32'h0000_0000);
    expQ.push_back(32'h0000_0004);
    pop = 1'b1;
    repeat (6) tick();
    pop = 1'b0;
    tick();
    checkEmptySb("s6_sb_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
